// File: rtl/systolic_6x6_bwd.sv
// systolic_6x6_bwd
//   Transpose matrix-vector engine for the backprop path: d = W^T * e.
//   Holds a 6x6 signed fixed-point weight matrix W (FRAC_BIT fractional
//   bits). It accepts six error elements e_0..e_5, one per handshake. It then
//   streams out six results d_0..d_5 over a valid/ready channel.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   w_wr_en/addr/data   weight write, addr = r*6+c, honoured only in IDLE
//   e_valid/ready/data  error element input stream (row order r = 0..5)
//   d_valid/ready/data  result output stream (column order c = 0..5)
//   d_idx, d_last       column index of d_data, high on the last column
//   busy                transaction in progress (ACC or OUT)

// One column of the transpose product. The column sees every row weight
// W[0..5][c]. It multiplies the selected row weight by the incoming error
// element and accumulates the product.
module systolic_6x6_bwd_lane #(
  parameter int WIDTH    = 16,
  parameter int FRAC_BIT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat,      // error element accepted this cycle
  input  logic                  first,     // beat is row 0: overwrite acc
  input  logic [2:0]            r_sel,     // row of the current beat
  input  logic [5:0][WIDTH-1:0] w_col,     // W[r][c] for r = 0..5
  input  logic [WIDTH-1:0]      e_data,
  output logic [WIDTH-1:0]      res        // saturated result of acc_nxt
);
  // Six full-range products fit in 2*WIDTH+3 bits without overflow.
  localparam int AW = 2*WIDTH + 3;
  localparam int PW = 2*WIDTH;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] w_sel;
  logic signed [WIDTH-1:0] e_s;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    acc, acc_nxt, shifted;

  assign w_sel = (r_sel < 3'd6) ? $signed(w_col[r_sel]) : '0;
  assign e_s   = $signed(e_data);
  assign prod  = PW'(w_sel) * PW'(e_s);

  always_comb begin
    acc_nxt = acc;
    if (beat) acc_nxt = (first ? '0 : acc) + AW'(prod);
  end

  // The result is converted from acc_nxt rather than acc. The output
  // register can then capture column 0 on the same edge that absorbs the
  // last row. Outside a beat, acc_nxt equals acc.
  assign shifted = acc_nxt >>> FRAC_BIT;

  always_comb begin
    if (shifted > SAT_MAX)      res = SAT_MAX[WIDTH-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[WIDTH-1:0];
    else                        res = shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else     acc <= acc_nxt;
  end
endmodule

module systolic_6x6_bwd #(
  parameter int WIDTH    = 16,
  parameter int FRAC_BIT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_wr_en,
  input  logic [5:0]       w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             e_valid,
  output logic             e_ready,
  input  logic [WIDTH-1:0] e_data,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [WIDTH-1:0] d_data,
  output logic [2:0]       d_idx,
  output logic             d_last,
  output logic             busy
);
  localparam int N = 6;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t                      state, state_nxt;
  logic [2:0]                  r_cnt;
  logic                        en_q;       // low only in the cycle after a reset edge
  logic [N*N-1:0][WIDTH-1:0]   w_flat;     // W[r][c] at index r*6+c
  logic [N-1:0][WIDTH-1:0]     res;
  logic                        accept, last_beat, out_fire, wr_ok;

  assign e_ready   = en_q && (state != S_OUT);
  assign accept    = e_valid && e_ready;
  assign last_beat = accept && (r_cnt == 3'd5);
  assign out_fire  = d_valid && d_ready;
  assign busy      = (state != S_IDLE);
  // A write that coincides with the first accepted beat is dropped. That
  // beat has already used the old weight.
  assign wr_ok     = w_wr_en && (state == S_IDLE) && !accept && (w_addr < 6'd36);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)             state_nxt = S_ACC;
      S_ACC:   if (last_beat)          state_nxt = S_OUT;
      S_OUT:   if (out_fire && d_last) state_nxt = S_IDLE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  genvar c, r;
  generate
    for (c = 0; c < N; c++) begin : g_col
      logic [N-1:0][WIDTH-1:0] w_col;
      for (r = 0; r < N; r++) begin : g_row
        assign w_col[r] = w_flat[r*N + c];
      end
      systolic_6x6_bwd_lane #(.WIDTH(WIDTH), .FRAC_BIT(FRAC_BIT)) u_lane (
        .clk    (clk),
        .rst    (rst),
        .beat   (accept),
        .first  (r_cnt == 3'd0),
        .r_sel  (r_cnt),
        .w_col  (w_col),
        .e_data (e_data),
        .res    (res[c])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      r_cnt   <= '0;
      en_q    <= 1'b0;
      w_flat  <= '0;
      d_valid <= 1'b0;
      d_data  <= '0;
      d_idx   <= '0;
      d_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      en_q  <= 1'b1;

      if (accept)                   r_cnt <= r_cnt + 3'd1;
      else if (out_fire && d_last)  r_cnt <= '0;

      if (wr_ok) w_flat[w_addr] <= w_data;

      // Output register: load column 0 with the last row. Then step one
      // column per handshake. Everything holds while the consumer stalls.
      if (last_beat) begin
        d_valid <= 1'b1;
        d_idx   <= '0;
        d_last  <= 1'b0;
        d_data  <= res[0];
      end else if (out_fire) begin
        if (d_last) begin
          d_valid <= 1'b0;
          d_idx   <= '0;
          d_last  <= 1'b0;
          d_data  <= '0;
        end else begin
          d_idx   <= d_idx + 3'd1;
          d_last  <= (d_idx == 3'd4);
          d_data  <= res[d_idx + 3'd1];
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_6x6_bwd.sv
module tb_systolic_6x6_bwd;
  localparam int WIDTH = 16;
  localparam int NT    = 8;

  typedef logic signed [WIDTH-1:0] wmat_t [36];
  typedef logic signed [WIDTH-1:0] vec6_t [6];
  typedef struct { wmat_t w; vec6_t e; vec6_t d; } tvec_t;
  typedef struct { logic signed [WIDTH-1:0] data; logic [2:0] idx; logic last; } exp_t;

  logic                    clk, rst, w_wr_en, e_valid, e_ready, d_valid, d_ready, d_last, busy;
  logic [5:0]              w_addr;
  logic signed [WIDTH-1:0] w_data, e_data, d_data;
  logic [2:0]              d_idx;

  exp_t  sb[$];
  tvec_t tv [NT];
  wmat_t ident;
  vec6_t ev, dv;
  int    checks = 0, failures = 0;

  systolic_6x6_bwd #(.WIDTH(WIDTH), .FRAC_BIT(10)) dut (
    .clk(clk), .rst(rst), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .e_valid(e_valid), .e_ready(e_ready), .e_data(e_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_idx(d_idx),
    .d_last(d_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: wide sum, arithmetic shift, clamp.
  task automatic model(input wmat_t w, input vec6_t e, output vec6_t d);
    for (int cc = 0; cc < 6; cc++) begin
      longint s = 0;
      for (int rr = 0; rr < 6; rr++) s += longint'(w[rr*6+cc]) * longint'(e[rr]);
      s = s >>> 10;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      d[cc] = WIDTH'(s);
    end
  endtask

  task automatic push_exp(input vec6_t d);
    for (int i = 0; i < 6; i++) sb.push_back('{data: d[i], idx: 3'(i), last: (i == 5)});
  endtask

  task automatic load_w(input wmat_t w);
    for (int a = 0; a < 36; a++) begin
      w_wr_en = 1'b1; w_addr = 6'(a); w_data = w[a];
      @(negedge clk);
    end
    w_wr_en = 1'b0;
  endtask

  task automatic beat(input logic signed [WIDTH-1:0] e, input logic wr,
                      input logic [5:0] a, input logic signed [WIDTH-1:0] wd);
    e_valid = 1'b1; e_data = e; w_wr_en = wr; w_addr = a; w_data = wd;
    @(negedge clk);
    e_valid = 1'b0; w_wr_en = 1'b0;
  endtask

  task automatic send_e(input vec6_t e);
    for (int i = 0; i < 6; i++) begin
      chk("e_ready_load", e_ready, 1);
      beat(e[i], 1'b0, 6'd0, '0);
    end
    chk("lat_d_valid", d_valid, 1);
    chk("lat_d_idx", d_idx, 0);
    chk("lat_e_ready", e_ready, 0);
    chk("lat_busy", busy, 1);
  endtask

  task automatic wait_done(input int n_exp);
    int k = 0;
    while (d_valid && k < 40) begin
      chk("out_e_ready", e_ready, 0);
      @(negedge clk);
      k++;
    end
    chk("done_in_time", (k < 40), 1);
    if (n_exp > 0) chk("out_cycles", k, n_exp);
    chk("idle_e_ready", e_ready, 1);
    chk("idle_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  // Scoreboard consumer: one pop per output handshake.
  always @(negedge clk) begin : mon
    exp_t x;
    #1;
    if (!rst && d_valid && d_ready) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL d_unexpected: got idx %0d data %0d expected no output", d_idx, d_data);
      end else begin
        x = sb.pop_front();
        chk("d_data", d_data, x.data);
        chk("d_idx", d_idx, x.idx);
        chk("d_last", d_last, x.last);
      end
    end
  end

  initial begin
    rst = 1'b1; w_wr_en = 1'b0; w_addr = '0; w_data = '0;
    e_valid = 1'b0; e_data = '0; d_ready = 1'b1;

    for (int a = 0; a < 36; a++) ident[a] = (a % 7 == 0) ? 16'sd1024 : 16'sd0;
    for (int i = 0; i < NT; i++) begin
      for (int a = 0; a < 36; a++) tv[i].w[a] = '0;
      for (int k = 0; k < 6; k++) begin tv[i].e[k] = '0; tv[i].d[k] = '0; end
    end
    // identity
    tv[0].w = ident;
    tv[0].e = '{16'sd1024, 16'sd2048, -16'sd1024, 16'sd0, 16'sd512, 16'sd3072};
    tv[0].d = '{16'sd1024, 16'sd2048, -16'sd1024, 16'sd0, 16'sd512, 16'sd3072};
    // transpose: W[0][1] lands in d1
    tv[1].w[1] = 16'sd2048; tv[1].e[0] = 16'sd1024; tv[1].d[1] = 16'sd2048;
    // converse: W[1][0] with e1 = 0 contributes nothing
    tv[2].w[6] = 16'sd2048; tv[2].e[0] = 16'sd1024;
    // positive / negative saturation
    for (int a = 0; a < 36; a++) begin tv[3].w[a] = 16'sd32767; tv[4].w[a] = 16'sd32767; end
    for (int k = 0; k < 6; k++) begin
      tv[3].e[k] = 16'sd32767;  tv[3].d[k] = 16'sd32767;
      tv[4].e[k] = -16'sd32768; tv[4].d[k] = -16'sd32768;
    end
    // floor of -1/1024
    tv[5].w[0] = 16'sd1; tv[5].e[0] = -16'sd1; tv[5].d[0] = -16'sd1;
    // random mixes, expected from the reference model
    for (int i = 6; i < NT; i++) begin
      for (int a = 0; a < 36; a++) tv[i].w[a] = WIDTH'(int'($urandom_range(8192)) - 4096);
      for (int k = 0; k < 6; k++)  tv[i].e[k] = WIDTH'(int'($urandom_range(8192)) - 4096);
      model(tv[i].w, tv[i].e, tv[i].d);
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_e_ready", e_ready, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_d_idx", d_idx, 0);
    chk("rst_d_last", d_last, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_e_ready", e_ready, 1);

    for (int i = 0; i < NT; i++) begin
      load_w(tv[i].w);
      push_exp(tv[i].d);
      send_e(tv[i].e);
      wait_done(6);
    end

    // Backpressure: stall 3 cycles at column 2
    begin
      int g = 0;
      load_w(ident);
      for (int k = 0; k < 6; k++) ev[k] = WIDTH'((k + 1) * 1024);
      push_exp(ev);
      send_e(ev);
      while (d_idx != 3'd2 && g < 20) begin @(negedge clk); g++; end
      chk("bp_reach_idx2", (g < 20), 1);
      d_ready = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("bp_d_data", d_data, 3072);
        chk("bp_d_idx", d_idx, 2);
        chk("bp_d_valid", d_valid, 1);
        chk("bp_e_ready", e_ready, 0);
      end
      d_ready = 1'b1;
      wait_done(-1);
    end

    // Write protection: first-beat, ACC, OUT and out-of-range writes all ignored
    load_w(ident);
    for (int k = 0; k < 6; k++) dv[k] = '0;
    dv[0] = 16'sd1024;
    push_exp(dv);
    beat(16'sd1024, 1'b1, 6'd1, 16'sd2048);
    beat(16'sd0, 1'b1, 6'd0, 16'sd4096);
    for (int k = 0; k < 4; k++) beat(16'sd0, 1'b0, 6'd0, '0);
    chk("wp_d_valid", d_valid, 1);
    w_wr_en = 1'b1; w_addr = 6'd2; w_data = 16'sd3000;
    wait_done(6);
    w_wr_en = 1'b0;
    beat(16'sd0, 1'b0, 6'd0, '0);
    // the beat above was accepted as row 0 of a new vector; finish it
    for (int k = 0; k < 6; k++) ev[k] = '0;
    push_exp(ev);
    for (int k = 0; k < 5; k++) beat(16'sd0, 1'b0, 6'd0, '0);
    wait_done(6);
    w_wr_en = 1'b1; w_addr = 6'd40; w_data = 16'sd32767; @(negedge clk);
    w_addr = 6'd63; @(negedge clk);
    w_wr_en = 1'b0;
    for (int k = 0; k < 6; k++) begin ev[k] = 16'sd1024; dv[k] = 16'sd1024; end
    push_exp(dv);
    send_e(ev);
    wait_done(6);

    // Reset mid-operation
    load_w(ident);
    for (int k = 0; k < 3; k++) beat(16'sd1024, 1'b0, 6'd0, '0);
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_d_valid", d_valid, 0);
    chk("mid_rst_e_ready", e_ready, 0);
    chk("mid_rst_d_idx", d_idx, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_post_e_ready", e_ready, 1);
    for (int k = 0; k < 6; k++) begin ev[k] = 16'sd1024; dv[k] = '0; end
    push_exp(dv);   // weights cleared by reset
    send_e(ev);
    wait_done(6);
    load_w(ident);
    for (int k = 0; k < 6; k++) begin ev[k] = 16'sd512; dv[k] = 16'sd512; end
    push_exp(dv);
    send_e(ev);
    wait_done(6);

    chk("sb_final_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
